sort_stream: RTL and testbench

Streaming N-entry sorter: a parametrised successor of the fixed 4-entry, 8-bit sort2 sorter. It collects a frame of N unsigned samples over a valid/ready input, sorts them in place with an odd-even transposition network (one pass per clock), and streams the sorted frame out over a valid/ready output. Sort direction is selectable per frame. It sits between a sample source and a downstream consumer in the EDA7 datapath.

---
 rtl/sort_stream_if.sv | 35 +++
 rtl/sort_stream.sv | 124 ++++++++++++
 tb/tb_sort_stream.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sort_stream_if.sv
// Handshake bundle for sort_stream: sample input, sorted output and status flags.
// out_idx is present only when SORTSTREAM_INDEX_EN is defined.
interface sort_stream_if #(
    parameter int W = 8,
    parameter int N = 4
);
    logic [W-1:0]         in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 desc;
    logic [W-1:0]         out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
`ifdef SORTSTREAM_INDEX_EN
    logic [$clog2(N)-1:0] out_idx;
`endif

    modport slave (
        input  in_data, in_valid, desc, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
`ifdef SORTSTREAM_INDEX_EN
        , output out_idx
`endif
    );

    modport master (
        output in_data, in_valid, desc, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
`ifdef SORTSTREAM_INDEX_EN
        , input out_idx
`endif
    );
endinterface

// File: rtl/sort_stream.sv
// Streaming N-entry sorter: load a frame, odd-even transposition sort (one pass per clock), stream out.
// Define SORTSTREAM_INDEX_EN to carry each sample's arrival index alongside it onto out_idx.
module sort_stream #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          reset,
    sort_stream_if.slave  bus
);
    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [IW-1:0] pass_q, pass_d;
    logic          desc_q, desc_d;
    logic [W-1:0]  data_q [N];
    logic [W-1:0]  data_d [N];
`ifdef SORTSTREAM_INDEX_EN
    logic [IW-1:0] idx_q [N];
    logic [IW-1:0] idx_d [N];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            rd_q    <= '0;
            pass_q  <= '0;
            desc_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
`ifdef SORTSTREAM_INDEX_EN
                idx_q[i]  <= '0;
`endif
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            pass_q  <= pass_d;
            desc_q  <= desc_d;
            data_q  <= data_d;
`ifdef SORTSTREAM_INDEX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        pass_d  = pass_q;
        desc_d  = desc_q;
        data_d  = data_q;
`ifdef SORTSTREAM_INDEX_EN
        idx_d   = idx_q;
`endif
        unique case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    data_d[cnt_q] = bus.in_data;
`ifdef SORTSTREAM_INDEX_EN
                    idx_d[cnt_q]  = cnt_q;
`endif
                    if (cnt_q == LAST) begin
                        desc_d  = bus.desc;
                        cnt_d   = '0;
                        pass_d  = '0;
                        state_d = SORT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SORT: begin
                // Pairs in one pass are disjoint, so every swap reads the pre-pass contents.
                for (int i = 0; i < N - 1; i++) begin
                    if (i[0] == pass_q[0]) begin
                        if (desc_q ? (data_q[i] < data_q[i+1]) : (data_q[i] > data_q[i+1])) begin
                            data_d[i]   = data_q[i+1];
                            data_d[i+1] = data_q[i];
`ifdef SORTSTREAM_INDEX_EN
                            idx_d[i]    = idx_q[i+1];
                            idx_d[i+1]  = idx_q[i];
`endif
                        end
                    end
                end
                if (pass_q == LAST) begin
                    rd_d    = '0;
                    state_d = OUT;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (rd_q == LAST) begin
                        rd_d    = '0;
                        state_d = LOAD;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign bus.in_ready  = (state_q == LOAD) && !reset;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = data_q[rd_q];
    assign bus.out_last  = (state_q == OUT) && (rd_q == LAST);
    assign bus.busy      = (state_q != LOAD);
`ifdef SORTSTREAM_INDEX_EN
    assign bus.out_idx   = idx_q[rd_q];
`endif
endmodule

// File: tb/tb_sort_stream.sv
// Self-checking bench for sort_stream: N=4 and N=8 instances, directed and random frames,
// compared against a stable insertion-sort reference model.
module tb_sort_stream;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [7:0] frame4 [4];
    logic [7:0] frame8 [8];

    sort_stream_if #(.W(8), .N(4)) bus4 ();
    sort_stream_if #(.W(8), .N(8)) bus8 ();

    sort_stream #(.W(8), .N(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    sort_stream #(.W(8), .N(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One N=4 frame: load (optional gaps), check sort latency, drain (optional stalls), compare with model.
    task automatic applyStimulus(input logic [7:0] v [4], input logic d, input bit stall,
                                 input bit holdValid, input bit gaps);
        logic [7:0] ev [4];
        logic [1:0] ei [4];
        logic [7:0] tv;
        logic [1:0] ti;
        for (int k = 0; k < 4; k++) begin
            ev[k] = v[k];
            ei[k] = k[1:0];
        end
        for (int a = 1; a < 4; a++)
            for (int b = a; b > 0; b--)
                if (d ? (ev[b] > ev[b-1]) : (ev[b] < ev[b-1])) begin
                    tv = ev[b]; ev[b] = ev[b-1]; ev[b-1] = tv;
                    ti = ei[b]; ei[b] = ei[b-1]; ei[b-1] = ti;
                end

        for (int k = 0; k < 4; k++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    bus4.in_valid = 1'b0;
                    bus4.desc     = ~d;
                end
            @(negedge clk);
            bus4.in_valid = 1'b1;
            bus4.in_data  = v[k];
            bus4.desc     = (k == 3) ? d : ~d;
            checkOutput("in_ready_load", 32'(bus4.in_ready), 32'd1);
        end
        @(negedge clk);
        bus4.in_valid = holdValid;
        bus4.in_data  = 8'($urandom);
        bus4.desc     = ~d;
        checkOutput("in_ready_sort", 32'(bus4.in_ready), 32'd0);
        checkOutput("busy_sort", 32'(bus4.busy), 32'd1);
        checkOutput("out_valid_sort", 32'(bus4.out_valid), 32'd0);
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            bus4.in_data = 8'($urandom);
            checkOutput("out_valid_early", 32'(bus4.out_valid), 32'd0);
        end
        @(negedge clk);
        checkOutput("latency_out_valid", 32'(bus4.out_valid), 32'd1);

        for (int r = 0; r < 4; r++) begin
            if (stall && r > 0) begin
                bus4.out_ready = 1'b0;
                checkOutput("stall_data_pre", 32'(bus4.out_data), 32'(ev[r]));
                @(negedge clk);
                checkOutput("stall_data_hold", 32'(bus4.out_data), 32'(ev[r]));
                checkOutput("stall_valid", 32'(bus4.out_valid), 32'd1);
                checkOutput("stall_in_ready", 32'(bus4.in_ready), 32'd0);
            end
            bus4.out_ready = 1'b1;
            checkOutput("out_data", 32'(bus4.out_data), 32'(ev[r]));
            checkOutput("out_last", 32'(bus4.out_last), (r == 3) ? 32'd1 : 32'd0);
            checkOutput("in_ready_out", 32'(bus4.in_ready), 32'd0);
`ifdef SORTSTREAM_INDEX_EN
            checkOutput("out_idx", 32'(bus4.out_idx), 32'(ei[r]));
`endif
            @(negedge clk);
        end
        checkOutput("in_ready_after", 32'(bus4.in_ready), 32'd1);
        checkOutput("out_valid_after", 32'(bus4.out_valid), 32'd0);
        checkOutput("busy_after", 32'(bus4.busy), 32'd0);
        bus4.in_valid = 1'b0;
    endtask

    // One back-to-back N=8 frame on the second instance.
    task automatic applyStimulus8(input logic [7:0] v [8], input logic d);
        logic [7:0] ev [8];
        logic [7:0] tv;
        for (int k = 0; k < 8; k++) ev[k] = v[k];
        for (int a = 1; a < 8; a++)
            for (int b = a; b > 0; b--)
                if (d ? (ev[b] > ev[b-1]) : (ev[b] < ev[b-1])) begin
                    tv = ev[b]; ev[b] = ev[b-1]; ev[b-1] = tv;
                end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus8.in_valid = 1'b1;
            bus8.in_data  = v[k];
            bus8.desc     = d;
            checkOutput("n8_in_ready", 32'(bus8.in_ready), 32'd1);
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            checkOutput("n8_out_valid_early", 32'(bus8.out_valid), 32'd0);
        end
        @(negedge clk);
        checkOutput("n8_latency", 32'(bus8.out_valid), 32'd1);
        for (int r = 0; r < 8; r++) begin
            checkOutput("n8_out_data", 32'(bus8.out_data), 32'(ev[r]));
            checkOutput("n8_out_last", 32'(bus8.out_last), (r == 7) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        checkOutput("n8_in_ready_after", 32'(bus8.in_ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.desc = 1'b0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.desc = 1'b0; bus8.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 32'(bus4.in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("reset_out_last", 32'(bus4.out_last), 32'd0);
        checkOutput("reset_busy", 32'(bus4.busy), 32'd0);
`ifdef SORTSTREAM_INDEX_EN
        checkOutput("reset_out_idx", 32'(bus4.out_idx), 32'd0);
`endif
        reset = 1'b0;
        #1;
        checkOutput("release_in_ready", 32'(bus4.in_ready), 32'd1);

        frame4 = '{8'd9, 8'd3, 8'd7, 8'd1};
        applyStimulus(frame4, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(frame4, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(frame4, 1'b0, 1'b1, 1'b1, 1'b0);
        frame4 = '{8'd5, 8'd2, 8'd5, 8'd2};
        applyStimulus(frame4, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(frame4, 1'b1, 1'b0, 1'b0, 1'b0);
        frame4 = '{8'd0, 8'd255, 8'd255, 8'd0};
        applyStimulus(frame4, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 4; k++)
                frame4[k] = (f < 4) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            applyStimulus(frame4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b1);
        end

        // Abort a frame two passes into sorting.
        frame4 = '{8'd200, 8'd100, 8'd150, 8'd50};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus4.in_valid = 1'b1;
            bus4.in_data  = frame4[k];
            bus4.desc     = 1'b1;
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("abort_busy", 32'(bus4.busy), 32'd0);
        checkOutput("abort_in_ready", 32'(bus4.in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_release_ready", 32'(bus4.in_ready), 32'd1);
        frame4 = '{8'd4, 8'd3, 8'd2, 8'd1};
        applyStimulus(frame4, 1'b0, 1'b0, 1'b0, 1'b0);

        frame8 = '{8'd255, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd0};
        applyStimulus8(frame8, 1'b0);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) frame8[k] = 8'($urandom_range(0, 31));
            applyStimulus8(frame8, 1'(f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
